// File: rtl/rc5_keygen_param.sv
// rc5_keygen_param: RC5-W/R/B key expansion, one mixing iteration per clock.
// Optional macro RC5_KEYGEN_ZEROIZE_EN adds a synchronous zeroize input and clears L once expansion completes.
module rc5_keygen_param #(
  parameter int W = 16,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef RC5_KEYGEN_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic [B*8-1:0]       key,
  output logic [2*(R+1)*W-1:0] sub,
  output logic                 busy,
  output logic                 ready
);
  localparam int T  = 2 * (R + 1);
  localparam int U  = W / 8;
  localparam int C  = (B + U - 1) / U;
  localparam int N  = 3 * ((T > C) ? T : C);
  localparam int LW = $clog2(W);
  localparam int IW = $clog2(T);
  localparam int JW = (C > 1) ? $clog2(C) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [63:0] P64 = (W == 16) ? 64'hB7E1 : (W == 32) ? 64'hB7E15163 : 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = (W == 16) ? 64'h9E37 : (W == 32) ? 64'h9E3779B9 : 64'h9E3779B97F4A7C15;
  localparam logic [W-1:0] P = P64[W-1:0];
  localparam logic [W-1:0] Q = Q64[W-1:0];
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MIX  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [W-1:0]   r_s [T];
  logic [W-1:0]   r_l [C];
  logic [W-1:0]   r_a, r_b;
  logic [IW-1:0]  r_i;
  logic [JW-1:0]  r_j;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_state;
  logic           r_busy, r_ready;
  logic [C*W-1:0] w_kp;
  logic [W-1:0]   w_sa, w_a, w_ab, w_lb, w_b;

  assign w_kp  = (C*W)'(key);
  assign w_sa  = r_s[r_i] + r_a + r_b;
  assign w_a   = {w_sa[W-4:0], w_sa[W-1:W-3]};
  assign w_ab  = w_a + r_b;
  assign w_lb  = r_l[r_j] + w_ab;
  assign w_b   = (w_lb << w_ab[LW-1:0]) | (w_lb >> (W - int'(w_ab[LW-1:0])));
  assign busy  = r_busy;
  assign ready = r_ready;

  // Expose the S table as a flat bus, word i at bits [i*W +: W].
  always_comb begin
    for (int m = 0; m < T; m++) sub[m*W +: W] = r_s[m];
  end

  // Key load and magic-constant init on start, then one mixing step per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < T; m++) r_s[m] <= '0;
      for (int m = 0; m < C; m++) r_l[m] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else
`ifdef RC5_KEYGEN_ZEROIZE_EN
    if (zeroize) begin
      for (int m = 0; m < T; m++) r_s[m] <= '0;
      for (int m = 0; m < C; m++) r_l[m] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else
`endif
    if (start && r_state != MIX) begin
      for (int m = 0; m < T; m++) r_s[m] <= P + W'(m) * Q;
      for (int m = 0; m < C; m++) r_l[m] <= w_kp[m*W +: W];
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      r_state <= MIX;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else if (r_state == MIX) begin
      r_s[r_i] <= w_a;
      r_l[r_j] <= w_b;
      r_a      <= w_a;
      r_b      <= w_b;
      r_i      <= (r_i == IW'(T - 1)) ? '0 : r_i + IW'(1);
      r_j      <= (r_j == JW'(C - 1)) ? '0 : r_j + JW'(1);
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == CW'(N - 1)) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
`ifdef RC5_KEYGEN_ZEROIZE_EN
        for (int m = 0; m < C; m++) r_l[m] <= '0;
`endif
      end
    end
  end
endmodule

// File: doc/rc5_keygen_param.md
Name: rc5_keygen_param

Overview:
Parametrised RC5-W/R/B key-expansion engine. It generalises the fixed 16-bit/12-round/16-byte key generator to any supported word size, round count and key length. Loads the secret key into L, initialises S from the P/Q magic constants, and performs the 3*max(T,C) mixing pass at one iteration per clock. The expanded table drives the RC5 encrypt/decrypt datapath, with a start/busy/ready handshake.

Parameters:
W, 16, word size in bits; legal values 16, 32, 64.
R, 12, round count, 1..255; T = 2*(R+1) subkeys.
B, 16, key length in bytes, 1..255; U = W/8, C = ceil(B/U) L-words.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to expand key.
key  in  B*8  secret key; byte k = key[8k+7:8k].
sub  out  T*W  expanded table, flattened; S[i] = sub[i*W+W-1:i*W].
busy  out  1  high while mixing.
ready  out  1  high when sub holds a complete, valid table.

Behaviour:
- Constants: W=16 P=0xB7E1 Q=0x9E37; W=32 P=0xB7E15163 Q=0x9E3779B9; W=64 P=0xB7E151628AED2A6B Q=0x9E3779B97F4A7C15.
- Reset (rst low, async): state IDLE; S, L, A, Bv, i, j, count all 0; sub=0, busy=0, ready=0.
- FSM states:
  - IDLE: on start=1 go to MIX.
  - MIX: stay there for N = 3*max(T,C) cycles, then go to DONE.
  - DONE: on start=1 go to MIX; otherwise hold.
- Start acceptance, in IDLE or DONE only, at that edge:
  - L[m] <= little-endian pack of key bytes m*U..m*U+U-1; bytes beyond B are zero.
  - S[i] <= P + i*Q mod 2^W.
  - A, Bv, i, j and count <= 0.
  - busy <= 1, ready <= 0.
- start while in MIX is ignored; the key is sampled only at the acceptance edge.
- Each MIX edge performs one iteration:
  - A' = (S[i]+A+Bv) <<< 3; S[i] <= A'.
  - Bv' = (L[j]+A'+Bv) <<< ((A'+Bv) mod W); L[j] <= Bv'.
  - i <= (i+1 == T) ? 0 : i+1; j <= (j+1 == C) ? 0 : j+1.
  - All additions are modulo 2^W. Rotate amount is the low log2(W) bits.
- On the edge completing iteration N-1: busy <= 0, ready <= 1, state DONE. Latency: ready is high N cycles after the accepting edge.
- sub reflects S combinationally in every state. It is valid for consumers only while ready=1.
- DONE: table and ready hold indefinitely. A new start restarts the expansion, with ready dropping at the accepting edge.
- Reset mid-MIX aborts immediately. All state clears and no partial ready is produced.
- C=1 (B <= U): j stays 0. T < C: i wraps multiple times; N uses C.

Optional Feature:
RC5_KEYGEN_ZEROIZE_EN
- Defined:
  - Adds input port "zeroize" (1 bit).
  - When zeroize=1 at a rising edge, in any state: S, L, A, Bv, i, j and count <= 0; ready=0, busy=0; state IDLE.
  - zeroize has priority over start in the same cycle.
  - Also, on the MIX-to-DONE edge, L is cleared to 0 so no key-derived L remains after expansion.
- Undefined: no zeroize port; L retains its final mixed values.

Test Plan:
- Reset: rst low with clk running -> sub=0, busy=0, ready=0; release; no start -> outputs unchanged for 100 cycles.
- W=16, R=12, B=16, key=0, start pulse -> one cycle after the accepting edge sub[0]=0xB7E1, sub[1]=0x5618, sub[2]=0xF44F. busy high for exactly 78 cycles; ready rises 78 cycles after the accepting edge. All 26 words match the software RC5 key-schedule model.
- W=32, R=12, B=16, key=0x0F0E..00 -> ready after 78 cycles; sub matches the model. Second start in DONE with a different key -> ready drops for 78 cycles, new table matches the model.
- Start pulses during MIX (cycles 5, 40) with a changing key -> ignored; result equals the table for the originally sampled key; completion still at 78 cycles.
- W=16, R=1, B=5 (T=4, C=3, N=12; partial last L-word zero-padded) and W=64, R=2, B=1 (C=1) -> ready after 12 and 18 cycles respectively; tables match the model.
- rst asserted asynchronously at MIX cycle 30 -> sub/busy/ready zero immediately. With RC5_KEYGEN_ZEROIZE_EN: zeroize at MIX cycle 30, simultaneous with start -> sub=0, ready=0, state IDLE; zeroize wins.
